// File: rtl/ddr4_cmd_decoder_pkg.sv
// ddr_cmd_pkg: command-vector bit positions, power-state encoding and the
// {ras_n, cas_n, we_n} opcode values shared by the command decoder.
package ddr_cmd_pkg;

  localparam int NCMD = 19;

  localparam int ACT_B  = 18;
  localparam int BST_B  = 17;
  localparam int CFG_B  = 16;
  localparam int CKEH_B = 15;
  localparam int CKEL_B = 14;
  localparam int DPD_B  = 13;
  localparam int DPDX_B = 12;
  localparam int MRR_B  = 11;
  localparam int MRW_B  = 10;
  localparam int PD_B   = 9;
  localparam int PDX_B  = 8;
  localparam int PR_B   = 7;
  localparam int PRA_B  = 6;
  localparam int RD_B   = 5;
  localparam int RDA_B  = 4;
  localparam int REF_B  = 3;
  localparam int SRF_B  = 2;
  localparam int WR_B   = 1;
  localparam int WRA_B  = 0;

  typedef enum logic [1:0] {
    PWR_ACTV = 2'd0,
    PWR_PDN  = 2'd1,
    PWR_SREF = 2'd2
  } pwr_state_e;

  // Follow-up command owed one cycle after a CKE edge pulse
  typedef enum logic [1:0] {
    FOL_NONE = 2'd0,
    FOL_PD   = 2'd1,
    FOL_PDX  = 2'd2
  } follow_e;

  localparam logic [2:0] OP_MRW   = 3'b000;
  localparam logic [2:0] OP_REF   = 3'b001;
  localparam logic [2:0] OP_PRE   = 3'b010;
  localparam logic [2:0] OP_NOP_A = 3'b011;
  localparam logic [2:0] OP_WR    = 3'b100;
  localparam logic [2:0] OP_RD    = 3'b101;
  localparam logic [2:0] OP_ZQ    = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  function automatic logic [NCMD-1:0] cmd_bit(input int idx);
    cmd_bit = {{(NCMD-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/ddr4_cmd_decoder_if.sv
// ddr4_cmd_decoder_if: DDR4 command/address pins plus the decoded command bus;
// master drives the pins, slave (the decoder) drives the decoded outputs.
interface ddr4_cmd_decoder_if #(
  parameter int ROWS = 131072,
  parameter int COLS = 1024,
  parameter int BGS  = 4,
  parameter int BPG  = 4
);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int BGW = $clog2(BGS);
  localparam int BAW = $clog2(BPG);
  localparam int NB  = BGS * BPG;

  logic           cke;
  logic           cs_n;
  logic           act_n;
  logic           ras_n;
  logic           cas_n;
  logic           we_n;
  logic [BGW-1:0] bg;
  logic [BAW-1:0] ba;
  logic [13:0]    A;

  logic [18:0]    commands;
  logic [NB-1:0]  bank_sel;
  logic [RW-1:0]  row;
  logic [CW-1:0]  column;
  logic [1:0]     pwr_state;
  logic           err;

  modport master (
    output cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, A,
    input  commands, bank_sel, row, column, pwr_state, err
  );

  modport slave (
    input  cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, A,
    output commands, bank_sel, row, column, pwr_state, err
  );
endinterface

// File: rtl/ddr4_cmd_decoder_bank_row_table.sv
// bank_row_table: per-bank open flag and open row. ACT writes an entry, PR/RDA/WRA
// clear one flag, PRA clears all flags; reads are combinational on the bank index.
module bank_row_table #(
  parameter  int NB = 16,
  parameter  int RW = 17,
  localparam int BW = $clog2(NB)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [BW-1:0] idx,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic          clr_one,
  input  logic          clr_all,
  output logic          rd_open,
  output logic [RW-1:0] rd_row,
  output logic          any_open
);

  logic [NB-1:0] open_r;
  logic [RW-1:0] row_r [NB];

  // Open flags: clear-all has priority, then ACT set, then single clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_r <= {NB{1'b0}};
    end else if (clr_all) begin
      open_r <= {NB{1'b0}};
    end else if (wr_en) begin
      open_r[idx] <= 1'b1;
    end else if (clr_one) begin
      open_r[idx] <= 1'b0;
    end
  end

  // Row storage; a closed bank keeps its last opened row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) begin
        row_r[i] <= {RW{1'b0}};
      end
    end else if (wr_en) begin
      row_r[idx] <= wr_row;
    end
  end

  assign rd_open  = open_r[idx];
  assign rd_row   = row_r[idx];
  assign any_open = |open_r;

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// ddr4_cmd_decoder: registers the DDR4 CA pins into a one-hot command vector, bank select,
// row/column and CKE power state. Define DDR_CMD_ERRCHK_EN for the sticky protocol err flag.
module ddr4_cmd_decoder
  import ddr_cmd_pkg::*;
#(
  parameter int ROWS = 131072,
  parameter int COLS = 1024,
  parameter int BGS  = 4,
  parameter int BPG  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  ddr4_cmd_decoder_if.slave bus
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int NB = BGS * BPG;
  localparam int BW = $clog2(NB);

  pwr_state_e      pwr_r, pwr_s;
  follow_e         follow_r, follow_s;
  logic            cke_prev_r;
  logic [NCMD-1:0] cmd_r, cmd_s;
  logic [NB-1:0]   bank_sel_r, bank_sel_s, onehot_s;
  logic [RW-1:0]   row_r, row_s, act_row_s, tbl_row_s;
  logic [CW-1:0]   column_r, column_s;
  logic            err_r, err_s;
  logic [BW-1:0]   bank_s;
  logic [2:0]      opcode_s;
  logic            rise_s, fall_s, srf_req_s, dec_en_s;
  logic            tbl_wr_s, tbl_clr_s, tbl_clr_all_s, tbl_open_s, any_open_s;
  logic            need_open_s, need_closed_s, need_idle_s;

  assign bank_s    = BW'(BPG * int'(bus.bg) + int'(bus.ba));
  assign opcode_s  = {bus.ras_n, bus.cas_n, bus.we_n};
  assign onehot_s  = {{(NB-1){1'b0}}, 1'b1} << bank_s;
  assign act_row_s = RW'({bus.ras_n, bus.cas_n, bus.we_n, bus.A});

  assign rise_s    = (pwr_r != PWR_ACTV) && !cke_prev_r && bus.cke;
  assign fall_s    = (pwr_r == PWR_ACTV) && cke_prev_r && !bus.cke;
  assign srf_req_s = !bus.cs_n && bus.act_n && (opcode_s == OP_REF);
  assign dec_en_s  = (pwr_r == PWR_ACTV) && cke_prev_r && bus.cke && !bus.cs_n;

  bank_row_table #(.NB(NB), .RW(RW)) u_tbl (
    .clk      (clk),
    .reset_n  (reset_n),
    .idx      (bank_s),
    .wr_en    (tbl_wr_s),
    .wr_row   (act_row_s),
    .clr_one  (tbl_clr_s),
    .clr_all  (tbl_clr_all_s),
    .rd_open  (tbl_open_s),
    .rd_row   (tbl_row_s),
    .any_open (any_open_s)
  );

  // Power FSM next state and command decode; CKE edges, then owed PD/PDX, then pins
  always_comb begin
    pwr_s         = pwr_r;
    follow_s      = FOL_NONE;
    cmd_s         = {NCMD{1'b0}};
    bank_sel_s    = {NB{1'b0}};
    row_s         = {RW{1'b0}};
    column_s      = {CW{1'b0}};
    tbl_wr_s      = 1'b0;
    tbl_clr_s     = 1'b0;
    tbl_clr_all_s = 1'b0;
    need_open_s   = 1'b0;
    need_closed_s = 1'b0;
    need_idle_s   = 1'b0;
    if (rise_s) begin
      cmd_s    = cmd_bit(CKEH_B);
      follow_s = FOL_PDX;
      pwr_s    = PWR_ACTV;
    end else if (fall_s && srf_req_s) begin
      cmd_s       = cmd_bit(SRF_B);
      bank_sel_s  = {NB{1'b1}};
      pwr_s       = PWR_SREF;
      need_idle_s = 1'b1;
    end else if (fall_s) begin
      cmd_s    = cmd_bit(CKEL_B);
      follow_s = FOL_PD;
      pwr_s    = PWR_PDN;
    end else if (follow_r == FOL_PD) begin
      cmd_s = cmd_bit(PD_B);
    end else if (follow_r == FOL_PDX) begin
      cmd_s = cmd_bit(PDX_B);
    end else if (dec_en_s && !bus.act_n) begin
      cmd_s         = cmd_bit(ACT_B);
      bank_sel_s    = onehot_s;
      row_s         = act_row_s;
      tbl_wr_s      = 1'b1;
      need_closed_s = 1'b1;
    end else if (dec_en_s) begin
      case (opcode_s)
        OP_MRW: cmd_s = cmd_bit(MRW_B);
        OP_REF: begin
          cmd_s       = cmd_bit(REF_B);
          bank_sel_s  = {NB{1'b1}};
          need_idle_s = 1'b1;
        end
        OP_PRE: begin
          if (bus.A[10]) begin
            cmd_s         = cmd_bit(PRA_B);
            bank_sel_s    = {NB{1'b1}};
            tbl_clr_all_s = 1'b1;
          end else begin
            cmd_s       = cmd_bit(PR_B);
            bank_sel_s  = onehot_s;
            tbl_clr_s   = 1'b1;
            need_open_s = 1'b1;
          end
        end
        OP_WR, OP_RD: begin
          if (opcode_s == OP_RD) begin
            cmd_s = bus.A[10] ? cmd_bit(RDA_B) : cmd_bit(RD_B);
          end else begin
            cmd_s = bus.A[10] ? cmd_bit(WRA_B) : cmd_bit(WR_B);
          end
          bank_sel_s  = onehot_s;
          row_s       = tbl_row_s;
          column_s    = bus.A[CW-1:0];
          tbl_clr_s   = bus.A[10];
          need_open_s = 1'b1;
        end
        OP_ZQ:   cmd_s = cmd_bit(CFG_B);
        default: cmd_s = {NCMD{1'b0}};
      endcase
    end else begin
      cmd_s = {NCMD{1'b0}};
    end
  end

`ifdef DDR_CMD_ERRCHK_EN
  logic op_is_cmd_s, viol_s;
  assign op_is_cmd_s = !bus.act_n || ((opcode_s != OP_NOP) && (opcode_s != OP_NOP_A));
  assign viol_s = (need_closed_s && tbl_open_s) || (need_open_s && !tbl_open_s) ||
                  (need_idle_s && any_open_s) ||
                  ((pwr_r != PWR_ACTV) && !bus.cs_n && op_is_cmd_s);
  assign err_s  = err_r || viol_s;
`else
  logic unused_chk_s;
  assign unused_chk_s = ^{need_open_s, need_closed_s, need_idle_s, tbl_open_s, any_open_s};
  assign err_s        = 1'b0;
`endif

  // Output and FSM state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwr_r      <= PWR_ACTV;
      follow_r   <= FOL_NONE;
      cke_prev_r <= 1'b0;
      cmd_r      <= {NCMD{1'b0}};
      bank_sel_r <= {NB{1'b0}};
      row_r      <= {RW{1'b0}};
      column_r   <= {CW{1'b0}};
      err_r      <= 1'b0;
    end else begin
      pwr_r      <= pwr_s;
      follow_r   <= follow_s;
      cke_prev_r <= bus.cke;
      cmd_r      <= cmd_s;
      bank_sel_r <= bank_sel_s;
      row_r      <= row_s;
      column_r   <= column_s;
      err_r      <= err_s;
    end
  end

  assign bus.commands  = cmd_r;
  assign bus.bank_sel  = bank_sel_r;
  assign bus.row       = row_r;
  assign bus.column    = column_r;
  assign bus.pwr_state = pwr_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Self-checking bench for ddr4_cmd_decoder: directed scenarios plus randomized pins,
// all compared against a command-level reference model of the decoder.
module tb_ddr4_cmd_decoder;

  localparam int ACT = 18, CFG = 16, CKEH = 15, CKEL = 14, MRW = 10, PD = 9, PDX = 8;
  localparam int PR = 7, PRA = 6, RD = 5, RDA = 4, REF = 3, SRF = 2, WR = 1, WRA = 0;
`ifdef DDR_CMD_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  ddr4_cmd_decoder_if bus ();
  ddr4_cmd_decoder dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: power state 0/1/2, sticky error, per-bank open flags/rows
  int m_pwr;
  bit m_cke_prev;
  bit m_err;
  bit m_open [16];
  int m_row  [16];
  int follow_q [$];
  int exp_cmd, exp_bsel, exp_row, exp_col;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".commands"}, 32'(bus.commands), exp_cmd);
    check_val({tag, ".bank_sel"}, 32'(bus.bank_sel), exp_bsel);
    check_val({tag, ".row"},      32'(bus.row),      exp_row);
    check_val({tag, ".column"},   32'(bus.column),   exp_col);
    check_val({tag, ".pwr"},      32'(bus.pwr_state), m_pwr);
    check_val({tag, ".err"},      32'(bus.err),      32'(ERRCHK && m_err));
  endtask

  function automatic bit any_open();
    any_open = 1'b0;
    foreach (m_open[i]) any_open |= m_open[i];
  endfunction

  task automatic model_reset();
    m_pwr = 0; m_cke_prev = 1'b0; m_err = 1'b0;
    follow_q.delete();
    foreach (m_open[i]) begin m_open[i] = 1'b0; m_row[i] = 0; end
    exp_cmd = 0; exp_bsel = 0; exp_row = 0; exp_col = 0;
  endtask

  // Predicts the outputs registered at the next edge from the pins now applied
  task automatic model_step();
    int b, op, a, pick;
    bit viol, cmd_pins;
    b = 4 * int'(bus.bg) + int'(bus.ba);
    op = int'({bus.ras_n, bus.cas_n, bus.we_n});
    a = int'(bus.A);
    pick = -1; exp_bsel = 0; exp_row = 0; exp_col = 0; viol = 1'b0;
    cmd_pins = !bus.cs_n && (!bus.act_n || (op != 7 && op != 3));
    if (m_pwr != 0 && cmd_pins) viol = 1'b1;
    if (m_pwr != 0 && !m_cke_prev && bus.cke) begin
      pick = CKEH; follow_q.delete(); follow_q.push_back(PDX); m_pwr = 0;
    end else if (m_pwr == 0 && m_cke_prev && !bus.cke) begin
      follow_q.delete();
      if (!bus.cs_n && bus.act_n && op == 1) begin
        pick = SRF; exp_bsel = 32'hFFFF; m_pwr = 2; viol |= any_open();
      end else begin
        pick = CKEL; follow_q.push_back(PD); m_pwr = 1;
      end
    end else if (follow_q.size() != 0) begin
      pick = follow_q.pop_front();
    end else if (m_pwr == 0 && m_cke_prev && bus.cke && !bus.cs_n) begin
      if (!bus.act_n) begin
        pick = ACT; exp_bsel = 1 << b; exp_row = op * 16384 + a;
        viol |= m_open[b]; m_open[b] = 1'b1; m_row[b] = exp_row;
      end else if (op == 0) begin
        pick = MRW;
      end else if (op == 1) begin
        pick = REF; exp_bsel = 32'hFFFF; viol |= any_open();
      end else if (op == 2 && a[10]) begin
        pick = PRA; exp_bsel = 32'hFFFF;
        foreach (m_open[i]) m_open[i] = 1'b0;
      end else if (op == 2) begin
        pick = PR; exp_bsel = 1 << b; viol |= !m_open[b]; m_open[b] = 1'b0;
      end else if (op == 4 || op == 5) begin
        if (op == 5) pick = a[10] ? RDA : RD;
        else         pick = a[10] ? WRA : WR;
        exp_bsel = 1 << b; exp_row = m_row[b]; exp_col = a % 1024;
        viol |= !m_open[b];
        if (a[10]) m_open[b] = 1'b0;
      end else if (op == 6) begin
        pick = CFG;
      end
    end
    m_cke_prev = bus.cke;
    exp_cmd = (pick < 0) ? 0 : (1 << pick);
    if (viol) m_err = 1'b1;
  endtask

  task automatic pins(input bit cke, input bit cs_n, input bit act_n, input int op,
                      input int bg, input int ba, input int a);
    bus.cke = cke; bus.cs_n = cs_n; bus.act_n = act_n;
    {bus.ras_n, bus.cas_n, bus.we_n} = 3'(op);
    bus.bg = 2'(bg); bus.ba = 2'(ba); bus.A = 14'(a);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    pins(1'b1, 1'b1, 1'b1, 7, 0, 0, 0);
    do_reset();
    cycle("idle");

    // Open row then read it back
    pins(1'b1, 1'b0, 1'b0, 5, 1, 2, 'h0123); cycle("act");
    check_val("tp_act_cmd", 32'(bus.commands), 32'h40000);
    check_val("tp_act_bsel", 32'(bus.bank_sel), 32'h40);
    check_val("tp_act_row", 32'(bus.row), 32'h14123);
    pins(1'b1, 1'b0, 1'b1, 5, 1, 2, 'h005); cycle("rd");
    check_val("tp_rd_cmd", 32'(bus.commands), 32'h20);
    check_val("tp_rd_row", 32'(bus.row), 32'h14123);
    check_val("tp_rd_col", 32'(bus.column), 32'h5);

    // Precharge then read a closed bank
    pins(1'b1, 1'b0, 1'b1, 2, 1, 2, 0); cycle("pr");
    check_val("tp_pr_cmd", 32'(bus.commands), 32'h80);
    pins(1'b1, 1'b0, 1'b1, 5, 1, 2, 5); cycle("rd_closed");
    check_val("tp_rdc_cmd", 32'(bus.commands), 32'h20);
    check_val("tp_rdc_err", 32'(bus.err), 32'(ERRCHK));

    // Auto-precharge write, then re-activate the same bank
    do_reset();
    pins(1'b1, 1'b1, 1'b1, 7, 0, 0, 0); cycle("idle2");
    pins(1'b1, 1'b0, 1'b0, 0, 0, 0, 0); cycle("act0");
    pins(1'b1, 1'b0, 1'b1, 4, 0, 0, 'h7F8); cycle("wra");
    check_val("tp_wra_cmd", 32'(bus.commands), 32'h1);
    check_val("tp_wra_col", 32'(bus.column), 32'h3F8);
    pins(1'b1, 1'b0, 1'b0, 0, 0, 0, 'h10); cycle("act0_again");
    check_val("tp_reopen_err", 32'(bus.err), 32'h0);

    // Power-down entry/exit with a read ignored while down
    pins(1'b1, 1'b1, 1'b1, 7, 0, 0, 0); cycle("pd_idle");
    pins(1'b0, 1'b1, 1'b1, 7, 0, 0, 0); cycle("ckel");
    check_val("tp_ckel", 32'(bus.commands), 32'h4000);
    check_val("tp_ckel_pwr", 32'(bus.pwr_state), 32'h1);
    cycle("pd");
    check_val("tp_pd", 32'(bus.commands), 32'h200);
    pins(1'b0, 1'b0, 1'b1, 5, 1, 2, 5); cycle("pd_rd");
    check_val("tp_pd_rd", 32'(bus.commands), 32'h0);
    pins(1'b0, 1'b1, 1'b1, 7, 0, 0, 0); cycle("pd_hold1");
    cycle("pd_hold2");
    pins(1'b1, 1'b1, 1'b1, 7, 0, 0, 0); cycle("ckeh");
    check_val("tp_ckeh", 32'(bus.commands), 32'h8000);
    check_val("tp_ckeh_pwr", 32'(bus.pwr_state), 32'h0);
    cycle("pdx");
    check_val("tp_pdx", 32'(bus.commands), 32'h100);

    // Self-refresh entry, then asynchronous reset while in SREF
    do_reset();
    pins(1'b1, 1'b1, 1'b1, 7, 0, 0, 0); cycle("idle3");
    pins(1'b0, 1'b0, 1'b1, 1, 0, 0, 0); cycle("srf");
    check_val("tp_srf", 32'(bus.commands), 32'h4);
    check_val("tp_srf_bsel", 32'(bus.bank_sel), 32'hFFFF);
    check_val("tp_srf_pwr", 32'(bus.pwr_state), 32'h2);
    pins(1'b0, 1'b1, 1'b1, 7, 0, 0, 0); cycle("sref_hold");
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("sref_rst");
    check_val("tp_rst_pwr", 32'(bus.pwr_state), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pins(1'b1, 1'b1, 1'b1, 7, 0, 0, 0); cycle("idle4");

    // Randomized pins, occasional CKE toggles and resets
    for (int i = 0; i < 3000; i++) begin
      bit cke_n;
      cke_n = bus.cke;
      if ($urandom_range(0, 19) == 0) cke_n = !cke_n;
      pins(cke_n, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 16383)));
      cycle("rnd");
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_decoder.md
Name: ddr4_cmd_decoder

Overview:
- Front-end stage directly upstream of the per-bank timing/storage blocks.
- Samples the DDR4 command/address pins every clock and decodes them into the 19-bit one-hot command vector the banks consume.
- Also produces a one-hot bank select, the row and column for the addressed bank, and tracks CKE power state.
- Keeps a per-bank open-row table, so RD/WR present the row opened by the earlier ACT.

Parameters:
- ROWS, 131072, rows per bank; row width RW = $clog2(ROWS) = 17.
- COLS, 1024, columns per row; column width CW = $clog2(COLS) = 10.
- BGS, 4, bank groups.
- BPG, 4, banks per group; NB = BGS*BPG.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cke  in  1  clock enable pin.
- cs_n  in  1  chip select, active low.
- act_n  in  1  activate, active low.
- ras_n  in  1  RAS / A16.
- cas_n  in  1  CAS / A15.
- we_n  in  1  WE / A14.
- bg  in  $clog2(BGS)  bank group.
- ba  in  $clog2(BPG)  bank address.
- A  in  14  address A13..A0 (A10 = auto-precharge / all-banks).
- commands  out  19  one-hot: ACT[18] … WRA[0]; same bit order as the bank command input.
- bank_sel  out  NB  one-hot target bank; all ones for PRA/REF/SRF.
- row  out  RW  ACT: decoded row; RD/WR: stored open row of the target bank.
- column  out  CW  A[9:0] on RD/RDA/WR/WRA, else 0.
- pwr_state  out  2  0 = ACTV, 1 = PDN, 2 = SREF.
- err  out  1  sticky protocol error.

Behaviour:
- All outputs are registered; latency is 1 cycle from pin sample to output.
- Reset (asynchronous, any time, including mid-burst or in SREF):
  - commands = 0, bank_sel = 0, row = 0, column = 0.
  - pwr_state = ACTV, err = 0.
  - All open flags cleared, row table cleared.
- Decode applies only when pwr_state = ACTV, cke = 1, previous cke = 1, and cs_n = 0. Otherwise no command is decoded (commands = 0).
- act_n = 0 → ACT. Row = {ras_n, cas_n, we_n, A[13:0]}. Set open[b] and write the row into the table.
- act_n = 1, {ras_n, cas_n, we_n}:
  - LLL → MRW.
  - LLH → REF if cke is held high; SRF if cke is sampled 0 in the same cycle. SRF moves to SREF.
  - LHL → PR (A10 = 0, clear open[b]) or PRA (A10 = 1, clear all; bank_sel all ones).
  - HLL → WR/WRA by A10.
  - HLH → RD/RDA by A10.
  - HHL (ZQ) → CFG.
  - HHH and LHH → no command.
- RDA/WRA clear open[b] in the same cycle the output is registered.
- CKE edges:
  - Fall while ACTV with no SRF → CKEL pulse plus PD, move to PDN.
  - Rise in PDN or SREF → CKEH pulse plus PDX, move to ACTV.
  - At most one command bit is ever asserted per cycle. An edge pulse is emitted as CKEL/CKEH in the edge cycle; PD/PDX follows in the next cycle.
- BST, DPD, DPDX and MRR are never asserted (no DDR4 equivalent).
- Pins other than cke are ignored in PDN/SREF.
- Bank index b = bg*BPG + ba.

Optional Feature:
- Macro: DDR_CMD_ERRCHK_EN.
- When defined, err latches to 1 on any of:
  - ACT to an open bank.
  - RD/WR/RDA/WRA or PR to a closed bank.
  - REF/SRF with any bank open.
  - cs_n = 0 with a command while not in ACTV.
- On an error, the command is still forwarded unchanged and the tables are updated as normal.
- err clears only on reset.
- When undefined, err is tied to 0 and the checking logic is absent.

Decomposition:
- Package ddr_cmd_pkg holds:
  - Command bit index constants (ACT_B = 18 … WRA_B = 0).
  - pwr_state encoding.
  - The 3-bit {ras_n, cas_n, we_n} opcode constants.
- Sub-module bank_row_table: NB entries × (open flag + RW-bit row), with ports:
  - Write-on-ACT.
  - Clear-one.
  - Clear-all.
  - Combinational read by bank index.

Test Plan:
- Open row: ACT bg=1, ba=2, {ras,cas,we}=HLH, A=0x0123, then RD at bg=1, ba=2, A=0x005 → cycle+1: commands[18]=1, bank_sel=1<<6, row=0x14123; next: commands[5]=1, row=0x14123, column=5.
- Precharge: after the ACT above, PR bg=1, ba=2 then RD there → commands[7], then commands[5]; with DDR_CMD_ERRCHK_EN, err=1 one cycle after the RD.
- Auto-precharge: ACT bank 0, WR with A10=1, A[9:0]=0x3F8 → commands[0]=1, column=0x3F8; a following ACT to bank 0 raises no err.
- Power-down: cke high→low with cs_n=1, hold 5 cycles, raise cke → CKEL pulse, PD, pwr_state=1; then CKEH pulse, PDX, pwr_state=0; any RD issued while down produces no output.
- Self-refresh: REF opcode with cke sampled 0 → commands[2]=1, bank_sel=0xFFFF, pwr_state=2; assert reset_n=0 mid-SREF → all outputs 0 and pwr_state=0 immediately, without waiting for a clock.
